// File: rtl/mem_data_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (port 0)
// and the DMA/debug loader (port 1), with a burst cap bounding starvation.
module mem_data_arbiter #(
    parameter int p_WORD_LEN  = 16,
    parameter int p_ADDR_LEN  = 10,
    parameter int p_MAX_BURST = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_we0,
    input  logic                  i_we1,
    input  logic [p_ADDR_LEN-1:0] i_addr0,
    input  logic [p_ADDR_LEN-1:0] i_addr1,
    input  logic [p_WORD_LEN-1:0] i_wdata0,
    input  logic [p_WORD_LEN-1:0] i_wdata1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [p_WORD_LEN-1:0] o_rdata0,
    output logic [p_WORD_LEN-1:0] o_rdata1,
    output logic [p_ADDR_LEN-1:0] o_mem_addr,
    output logic                  o_mem_wr_en,
    output logic [p_WORD_LEN-1:0] o_mem_wr_data,
    input  logic [p_WORD_LEN-1:0] i_mem_rd_data
);

    // state | meaning
    // IDLE  | nobody owns the memory
    // OWN0  | core port owns the memory
    // OWN1  | DMA/debug port owns the memory
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_OWN0 = 2'd1;
    localparam logic [1:0] c_OWN1 = 2'd2;

    localparam int              c_CW     = $clog2(p_MAX_BURST + 1);
    localparam logic [c_CW-1:0] c_MAX    = c_CW'(p_MAX_BURST);
    localparam logic [c_CW-1:0] c_CAP_M1 = c_CW'(p_MAX_BURST - 1);
    localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);

    logic [1:0]            state_q, state_d;
    logic [c_CW-1:0]       cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [p_WORD_LEN-1:0] rdata0_q, rdata0_d;
    logic [p_WORD_LEN-1:0] rdata1_q, rdata1_d;

    logic gnt0, gnt1, acc0, acc1;
    logic own1, req_own, req_oth, at_cap;

    assign gnt0 = (state_q == c_OWN0);
    assign gnt1 = (state_q == c_OWN1);
    assign acc0 = gnt0 & i_req0;
    assign acc1 = gnt1 & i_req1;

    // Owner-relative view so OWN0 and OWN1 share one transition rule.
    assign own1    = gnt1;
    assign req_own = own1 ? i_req1 : i_req0;
    assign req_oth = own1 ? i_req0 : i_req1;
    assign at_cap  = (cnt_q >= c_CAP_M1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            c_IDLE: begin
                cnt_d = '0;
                if (i_req0 && i_req1) state_d = last_q ? c_OWN0 : c_OWN1;
                else if (i_req0)      state_d = c_OWN0;
                else if (i_req1)      state_d = c_OWN1;
            end
            c_OWN0, c_OWN1: begin
                if (!req_own || (req_oth && at_cap)) begin
                    cnt_d  = '0;
                    last_d = own1;
                    if (req_oth) state_d = own1 ? c_OWN0 : c_OWN1;
                    else         state_d = c_IDLE;
                end else if (cnt_q != c_MAX) begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            default: begin
                state_d = c_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rvalid0_d = acc0 & ~i_we0;
        rvalid1_d = acc1 & ~i_we1;
        rdata0_d  = rvalid0_d ? i_mem_rd_data : rdata0_q;
        rdata1_d  = rvalid1_d ? i_mem_rd_data : rdata1_q;
    end

    always_comb begin
        o_mem_addr    = '0;
        o_mem_wr_data = '0;
        if (gnt0) begin
            o_mem_addr    = i_addr0;
            o_mem_wr_data = i_wdata0;
        end else if (gnt1) begin
            o_mem_addr    = i_addr1;
            o_mem_wr_data = i_wdata1;
        end
    end

    assign o_mem_wr_en = (acc0 & i_we0) | (acc1 & i_we1);
    assign o_gnt0      = gnt0;
    assign o_gnt1      = gnt1;
    assign o_rvalid0   = rvalid0_q;
    assign o_rvalid1   = rvalid1_q;
    assign o_rdata0    = rdata0_q;
    assign o_rdata1    = rdata1_q;

    // last_q resets to port 1 so the core wins the first contention.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= c_IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

endmodule
